control_unit: RTL and testbench

//  Sequencer that drives the datapath control strobes: fetch, decode of IR[31:27], per-class execute steps.

---
 rtl/control_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Moore sequencer for the datapath: fetches an instruction in T0..T2, decodes
// IR[31:27] in T3 and steps through the execute sequence of that instruction
// class, then returns to T0 (or parks in HALT).
//
// Ports
//   clock            rising-edge system clock
//   clear            synchronous active-low reset (forces RST)
//   IR               instruction register, IR[31:27] is the opcode
//   conOut           branch-condition flag, consulted in T6 of br only
//   Stop             halt request, honoured at the next instruction boundary
//   Run              1 in every state except HALT
//   Gra..write       one-hot-ish register/bus/memory strobes for the datapath
//   alu_op           ALU operation code, zero outside ALU steps
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int             OPW    = 5,
   parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
   input  logic           clock,
   input  logic           clear,
   input  logic [31:0]    IR,
   input  logic           conOut,
   input  logic           Stop,
   output logic           Run,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic           BAout,
   output logic           PCout,
   output logic           PCin,
   output logic           IncPC,
   output logic           IRin,
   output logic           MARin,
   output logic           MDRin,
   output logic           MDRout,
   output logic           Yin,
   output logic           Zin,
   output logic           Cout,
   output logic           Zhighout,
   output logic           Zlowout,
   output logic           HIin,
   output logic           HIout,
   output logic           LOin,
   output logic           LOout,
   output logic           InPortout,
   output logic           Out_portIn,
   output logic           conIn,
   output logic           R8_RAin,
   output logic           read,
   output logic           write,
   output logic [OPW-1:0] alu_op
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      C_ALU3 = 4'd0,  C_IMM  = 4'd1,  C_MD   = 4'd2,  C_UN   = 4'd3,
      C_LDI  = 4'd4,  C_LD   = 4'd5,  C_ST   = 4'd6,  C_BR   = 4'd7,
      C_JR   = 4'd8,  C_JAL  = 4'd9,  C_IN   = 4'd10, C_OUT  = 4'd11,
      C_MFHI = 4'd12, C_MFLO = 4'd13, C_HALT = 4'd14, C_NOP  = 4'd15
   } cls_t;

   state_t     state_q, state_d;
   logic [4:0] op_s;
   cls_t       cls_s;
   state_t     last_s;
   logic       ir_unused_s;

   assign op_s        = IR[31:27];
   assign ir_unused_s = ^IR[26:0];

   // Map an opcode onto its instruction class; undefined codes behave as nop.
   function automatic cls_t classify(input logic [4:0] op);
      cls_t c;
      if (op == 5'd0)                        c = C_LD;
      else if (op == 5'd1)                   c = C_LDI;
      else if (op == 5'd2)                   c = C_ST;
      else if (op <= 5'd11)                  c = C_ALU3;
      else if (op <= 5'd14)                  c = C_IMM;
      else if (op <= 5'd16)                  c = C_MD;
      else if (op <= 5'd18)                  c = C_UN;
      else if (op == 5'd19)                  c = C_BR;
      else if (op == 5'd20)                  c = C_JR;
      else if (op == 5'd21)                  c = C_JAL;
      else if (op == 5'd22)                  c = C_IN;
      else if (op == 5'd23)                  c = C_OUT;
      else if (op == 5'd24)                  c = C_MFHI;
      else if (op == 5'd25)                  c = C_MFLO;
      else if (op == 5'd27)                  c = C_HALT;
      else                                   c = C_NOP;
      return c;
   endfunction

   // Final execute step of each class; the step after it is an instruction boundary.
   function automatic state_t last_step(input cls_t c);
      state_t s;
      case (c)
         C_ALU3, C_IMM, C_LDI: s = S_T5;
         C_MD, C_ST, C_BR:     s = S_T6;
         C_LD:                 s = S_T7;
         C_UN, C_JAL:          s = S_T4;
         default:              s = S_T3;
      endcase
      return s;
   endfunction

   assign cls_s  = classify(op_s);
   assign last_s = last_step(cls_s);

   // State register with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; Stop is only honoured where T0 would otherwise be entered.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:  state_d = Stop ? S_HALT : S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (state_q != last_s) begin
               state_d = state_t'(state_q + 4'd1);
            end else if (cls_s == C_HALT || Stop) begin
               state_d = S_HALT;
            end else begin
               state_d = S_T0;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // Strobe decode from the current step and instruction class.
   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; Yin = 1'b0; Zin = 1'b0; Cout = 1'b0;
      Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0;
      LOout = 1'b0; InPortout = 1'b0; Out_portIn = 1'b0; conIn = 1'b0;
      R8_RAin = 1'b0; read = 1'b0; write = 1'b0;
      alu_op = {OPW{1'b0}};
      Run = (state_q != S_HALT);
      case (state_q)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
         S_T1: begin read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            case (cls_s)
               C_ALU3, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_MD:   begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_UN:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OPW'(op_s); end
               C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               C_BR:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
               C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               C_JAL:  begin PCout = 1'b1; R8_RAin = 1'b1; end
               C_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_OUT:  begin Gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1; end
               C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: begin end
            endcase
         end
         S_T4: begin
            case (cls_s)
               C_ALU3: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OPW'(op_s); end
               C_IMM:  begin Cout = 1'b1; Zin = 1'b1; alu_op = OPW'(op_s); end
               C_MD:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OPW'(op_s); end
               C_UN:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
               C_BR:   begin PCout = 1'b1; Yin = 1'b1; end
               C_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               default: begin end
            endcase
         end
         S_T5: begin
            case (cls_s)
               C_ALU3, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_MD:   begin Zlowout = 1'b1; LOin = 1'b1; end
               C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
               C_BR:   begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
               default: begin end
            endcase
         end
         S_T6: begin
            case (cls_s)
               C_MD:   begin Zhighout = 1'b1; HIin = 1'b1; end
               C_LD:   begin read = 1'b1; MDRin = 1'b1; end
               // Store drives the data register straight into MDR; read stays low
               // so the MDR mux takes the bus rather than memory.
               C_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; write = 1'b1; end
               C_BR: begin
                  if (conOut) begin
                     Zlowout = 1'b1; PCin = 1'b1;
                  end else begin
                     PCin = 1'b0;
                  end
               end
               default: begin end
            endcase
         end
         S_T7: begin
            if (cls_s == C_LD) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else begin
               MDRout = 1'b0;
            end
         end
         default: begin end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed bench: each instruction is launched at the T0 boundary and the
// expected per-cycle strobe pattern is pushed into a queue from a table of
// step masks; one negedge process pops and compares every queued cycle.
// -----------------------------------------------------------------------------
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear, conOut, Stop;
   logic [31:0] IR;
   logic        Run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin;
   logic        MARin, MDRin, MDRout, Yin, Zin, Cout, Zhighout, Zlowout, HIin;
   logic        HIout, LOin, LOout, InPortout, Out_portIn, conIn, R8_RAin, read, write;
   logic [4:0]  alu_op;

   int          n_tests = 0;
   int          n_fail  = 0;
   string       cur_name = "none";
   logic [33:0] exp_q[$];

   localparam logic [27:0] M_GRA = 28'h0000001, M_GRB = 28'h0000002, M_GRC = 28'h0000004;
   localparam logic [27:0] M_RIN = 28'h0000008, M_ROUT = 28'h0000010, M_BA = 28'h0000020;
   localparam logic [27:0] M_PCOUT = 28'h0000040, M_PCIN = 28'h0000080, M_INCPC = 28'h0000100;
   localparam logic [27:0] M_IRIN = 28'h0000200, M_MARIN = 28'h0000400, M_MDRIN = 28'h0000800;
   localparam logic [27:0] M_MDROUT = 28'h0001000, M_YIN = 28'h0002000, M_ZIN = 28'h0004000;
   localparam logic [27:0] M_COUT = 28'h0008000, M_ZHI = 28'h0010000, M_ZLO = 28'h0020000;
   localparam logic [27:0] M_HIIN = 28'h0040000, M_HIOUT = 28'h0080000, M_LOIN = 28'h0100000;
   localparam logic [27:0] M_LOOUT = 28'h0200000, M_INP = 28'h0400000, M_OUTP = 28'h0800000;
   localparam logic [27:0] M_CONIN = 28'h1000000, M_R8 = 28'h2000000, M_READ = 28'h4000000;
   localparam logic [27:0] M_WRITE = 28'h8000000;
   localparam logic [33:0] RST_V  = {1'b1, 5'd0, 28'd0};
   localparam logic [33:0] HALT_V = {1'b0, 5'd0, 28'd0};

   control_unit dut (
      .clock(clock), .clear(clear), .IR(IR), .conOut(conOut), .Stop(Stop), .Run(Run),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Cout(Cout),
      .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .HIout(HIout),
      .LOin(LOin), .LOout(LOout), .InPortout(InPortout), .Out_portIn(Out_portIn),
      .conIn(conIn), .R8_RAin(R8_RAin), .read(read), .write(write), .alu_op(alu_op)
   );

   always #5 clock = ~clock;

   // Number of execute cycles (T3 onward) for an opcode.
   function automatic int exec_len(input logic [4:0] op);
      if (op == 5'd0) return 5;
      if (op == 5'd2 || op == 5'd15 || op == 5'd16 || op == 5'd19) return 4;
      if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) return 3;
      if (op == 5'd17 || op == 5'd18 || op == 5'd21) return 2;
      return 1;
   endfunction

   // {alu_op, strobe mask} for execute cycle k (k=0 is T3).
   function automatic logic [32:0] exec_step(input logic [4:0] op, input int k, input logic cond);
      logic [27:0] m = 28'd0;
      logic [4:0]  a = 5'd0;
      if (op <= 5'd2 && k <= 1) begin
         if (k == 0) m = M_GRB | M_BA | M_YIN;
         else begin m = M_COUT | M_ZIN; a = 5'd3; end
      end else if (op == 5'd1) m = M_ZLO | M_GRA | M_RIN;
      else if (op == 5'd0) m = (k == 2) ? (M_ZLO | M_MARIN) : (k == 3) ? (M_READ | M_MDRIN) : (M_MDROUT | M_GRA | M_RIN);
      else if (op == 5'd2) m = (k == 2) ? (M_ZLO | M_MARIN) : (M_GRA | M_ROUT | M_MDRIN | M_WRITE);
      else if (op <= 5'd14) begin
         if (k == 0) m = M_GRB | M_ROUT | M_YIN;
         else if (k == 1) begin m = ((op <= 5'd11) ? (M_GRC | M_ROUT) : M_COUT) | M_ZIN; a = op; end
         else m = M_ZLO | M_GRA | M_RIN;
      end else if (op <= 5'd16) begin
         if (k == 0) m = M_GRA | M_ROUT | M_YIN;
         else if (k == 1) begin m = M_GRB | M_ROUT | M_ZIN; a = op; end
         else if (k == 2) m = M_ZLO | M_LOIN;
         else m = M_ZHI | M_HIIN;
      end else if (op <= 5'd18) begin
         if (k == 0) begin m = M_GRB | M_ROUT | M_ZIN; a = op; end
         else m = M_ZLO | M_GRA | M_RIN;
      end else if (op == 5'd19) begin
         if (k == 0) m = M_GRA | M_ROUT | M_CONIN;
         else if (k == 1) m = M_PCOUT | M_YIN;
         else if (k == 2) begin m = M_COUT | M_ZIN; a = 5'd3; end
         else m = cond ? (M_ZLO | M_PCIN) : 28'd0;
      end else if (op == 5'd20) m = M_GRA | M_ROUT | M_PCIN;
      else if (op == 5'd21) m = (k == 0) ? (M_PCOUT | M_R8) : (M_GRA | M_ROUT | M_PCIN);
      else if (op == 5'd22) m = M_INP | M_GRA | M_RIN;
      else if (op == 5'd23) m = M_GRA | M_ROUT | M_OUTP;
      else if (op == 5'd24) m = M_HIOUT | M_GRA | M_RIN;
      else if (op == 5'd25) m = M_LOOUT | M_GRA | M_RIN;
      else m = 28'd0;
      return {a, m};
   endfunction

   task automatic push_exec(input logic [31:0] ir, input logic cond, input int nsteps);
      exp_q.push_back({1'b1, 5'd0, M_PCOUT | M_MARIN | M_INCPC});
      exp_q.push_back({1'b1, 5'd0, M_READ | M_MDRIN});
      exp_q.push_back({1'b1, 5'd0, M_MDROUT | M_IRIN});
      for (int k = 0; k < nsteps; k++) exp_q.push_back({1'b1, exec_step(ir[31:27], k, cond)});
   endtask

   // Launch an instruction at the edge entering T0.
   task automatic launch(input logic [31:0] ir, input logic cond, input logic stp,
                         input int halts, input string name);
      @(posedge clock); #1;
      IR = ir; conOut = cond; Stop = stp; cur_name = name;
      push_exec(ir, cond, exec_len(ir[31:27]));
      for (int i = 0; i < halts; i++) exp_q.push_back(HALT_V);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         @(negedge clock); #1;
      end
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL timeout(%s): actual=%0d pending required=0", cur_name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      clear = 1'b0; Stop = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      cur_name = "reset";
      exp_q.push_back(RST_V);
      clear = 1'b1;
   endtask

   task automatic pin(input logic [32:0] act, input logic [32:0] req, input string name);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL pin_%s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Single compare point: every queued cycle is checked at the falling edge.
   always @(negedge clock) begin
      logic [33:0] e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = {Run, alu_op, write, read, R8_RAin, conIn, Out_portIn, InPortout, LOout, LOin,
              HIout, HIin, Zlowout, Zhighout, Cout, Zin, Yin, MDRout, MDRin, MARin, IRin,
              IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle(%s) t=%0t: actual=%h required=%h", cur_name, $time, a, e);
         end
      end
   end

   logic [31:0] prog [0:20] = '{
      32'h00880010, 32'h08000000, 32'h60000000, 32'h68000000, 32'h70000000,
      32'h38000000, 32'h58000000, 32'h78000000, 32'h80000000, 32'h88000000,
      32'h90000000, 32'hA0000000, 32'hA8000000, 32'hB0000000, 32'hB8000000,
      32'hC0000000, 32'hC8000000, 32'hD0000000, 32'hE0000000, 32'hF8000000,
      32'h10000000
   };

   initial begin
      clear = 1'b0; Stop = 1'b0; conOut = 1'b0; IR = 32'd0;

      // Hand-derived entries that pin the step table.
      pin(exec_step(5'd3, 1, 1'b0),  {5'd3, 28'h0004014}, "add_T4");
      pin(exec_step(5'd0, 1, 1'b0),  {5'd3, 28'h000C000}, "ld_T4");
      pin(exec_step(5'd0, 3, 1'b0),  {5'd0, 28'h4000800}, "ld_T6");
      pin(exec_step(5'd19, 3, 1'b1), {5'd0, 28'h0020080}, "br_T6_taken");
      pin(exec_step(5'd19, 3, 1'b0), {5'd0, 28'h0000000}, "br_T6_not");
      pin(33'(exec_len(5'd0)), 33'd5, "ld_len");

      do_reset();
      launch(32'h1A2B8000, 1'b0, 1'b0, 0, "add"); wait_drain();
      for (int i = 0; i < 21; i++) begin
         launch(prog[i], 1'b0, 1'b0, 0, $sformatf("prog%0d", i));
         wait_drain();
      end
      launch(32'h98000000, 1'b1, 1'b0, 0, "br_taken");     wait_drain();
      launch(32'h98000000, 1'b0, 1'b0, 0, "br_not_taken"); wait_drain();

      launch(32'hD8000000, 1'b0, 1'b0, 6, "halt"); wait_drain();
      do_reset();
      launch(32'h80000000, 1'b0, 1'b1, 5, "mul_stop"); wait_drain();
      do_reset();

      // st interrupted by clear during T4: no write, RST next, refetch after release.
      @(posedge clock); #1;
      IR = 32'h10000000; conOut = 1'b0; Stop = 1'b0; cur_name = "st_clear";
      push_exec(32'h10000000, 1'b0, 2);
      wait_drain();
      clear = 1'b0;
      exp_q.push_back(RST_V);
      exp_q.push_back(RST_V);
      wait_drain();
      clear = 1'b1;
      launch(32'h1A2B8000, 1'b0, 1'b0, 0, "add_after_clear"); wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
